// File: rtl/otter_mem_pkg.sv
// Shared definitions for the OTTER data-port arbiter: access sizes, the MMIO
// boundary and the arbiter state encoding.
package otter_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Addresses at or above this go to memory-mapped IO.
  localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

  typedef enum logic {
    IDLE,
    RD_DATA
  } arb_state_e;

endpackage

// File: rtl/otter_arb2.sv
// Two-way grant logic for the OTTER data-port arbiter.
// With OTTER_ARB_RR_EN defined, a conflict goes to the master not granted last;
// otherwise master 0 always wins and the pointer does not exist.
module otter_arb2 (
`ifdef OTTER_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

`ifdef OTTER_ARB_RR_EN
  // 0 = master 0 was granted last, 1 = master 1 was granted last.
  logic last_q, last_d;

  // Grant selection and pointer next-state; every grant moves the pointer.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    last_d = last_q;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end

  // Pointer register; reset value makes master 0 win the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: master 0 always wins.
  always_comb begin
    gnt0 = en & req0;
    gnt1 = en & req1 & ~req0;
  end
`endif

endmodule

// File: rtl/otter_mem_arbiter.sv
// Arbiter and sequencer sharing the OTTER memory data port (port 2) between the
// CPU (M0) and a secondary master (M1). One transaction at a time; a load holds
// address, size and sign through the read-return cycle because the memory sizes
// read data combinationally from them.
// Optional feature: define OTTER_ARB_RR_EN for round-robin arbitration.
module otter_mem_arbiter
  import otter_mem_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WD,
  input  logic [1:0]  M0_SIZE,
  input  logic        M0_SIGN,
  output logic        M0_GNT,
  output logic        M0_RVALID,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WD,
  input  logic [1:0]  M1_SIZE,
  input  logic        M1_SIGN,
  output logic        M1_GNT,
  output logic        M1_RVALID,
  output logic [31:0] RDATA,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_WD,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;  // 0 = M0, 1 = M1
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;

  logic        arb_en, gnt0, gnt1;
  logic        sel_we, sel_sign;
  logic [31:0] sel_addr, sel_wd;
  logic [1:0]  sel_size;

  // Grants only in IDLE and never while reset is asserted.
  assign arb_en = (state_q == IDLE) && !RST;

  otter_arb2 u_arb2 (
`ifdef OTTER_ARB_RR_EN
    .clk  (CLK),
    .rst  (RST),
`endif
    .en   (arb_en),
    .req0 (M0_REQ),
    .req1 (M1_REQ),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign M0_GNT = gnt0;
  assign M1_GNT = gnt1;
  assign RDATA  = MEM_DOUT2;

  // Attributes of the winning master.
  always_comb begin
    sel_we   = gnt1 ? M1_WE   : M0_WE;
    sel_addr = gnt1 ? M1_ADDR : M0_ADDR;
    sel_wd   = gnt1 ? M1_WD   : M0_WD;
    sel_size = gnt1 ? M1_SIZE : M0_SIZE;
    sel_sign = gnt1 ? M1_SIGN : M0_SIGN;
  end

  // Next-state, attribute capture and memory-port output muxing.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sign_d    = sign_q;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    MEM_ADDR2 = 32'h0;
    MEM_WD    = 32'h0;
    MEM_SIZE  = 2'd0;
    MEM_SIGN  = 1'b0;
    M0_RVALID = 1'b0;
    M1_RVALID = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          MEM_ADDR2 = sel_addr;
          MEM_WD    = sel_wd;
          MEM_SIZE  = sel_size;
          MEM_SIGN  = sel_sign;
          MEM_WE2   = sel_we;
          MEM_RDEN2 = ~sel_we;
          // Stores finish this cycle; loads need the return cycle.
          if (!sel_we) begin
            state_d = RD_DATA;
            owner_d = gnt1;
            addr_d  = sel_addr;
            size_d  = sel_size;
            sign_d  = sel_sign;
          end
        end
      end
      RD_DATA: begin
        MEM_ADDR2 = addr_q;
        MEM_SIZE  = size_q;
        MEM_SIGN  = sign_q;
        M0_RVALID = !RST && !owner_q;
        M1_RVALID = !RST && owner_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and load-attribute registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
    end
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Scoreboard bench for otter_mem_arbiter: a transaction-level model predicts
// grants and load returns; a negedge monitor compares against the DUT.
module tb_otter_mem_arbiter;
  import otter_mem_pkg::*;

`ifdef OTTER_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        M0_REQ, M0_WE, M0_SIGN, M0_GNT, M0_RVALID;
  logic [31:0] M0_ADDR, M0_WD;
  logic [1:0]  M0_SIZE;
  logic        M1_REQ, M1_WE, M1_SIGN, M1_GNT, M1_RVALID;
  logic [31:0] M1_ADDR, M1_WD;
  logic [1:0]  M1_SIZE;
  logic [31:0] RDATA, MEM_ADDR2, MEM_WD, MEM_DOUT2;
  logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
  logic [1:0]  MEM_SIZE;

  always #5 CLK = ~CLK;

  otter_mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WD(M0_WD),
    .M0_SIZE(M0_SIZE), .M0_SIGN(M0_SIGN), .M0_GNT(M0_GNT), .M0_RVALID(M0_RVALID),
    .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WD(M1_WD),
    .M1_SIZE(M1_SIZE), .M1_SIGN(M1_SIGN), .M1_GNT(M1_GNT), .M1_RVALID(M1_RVALID),
    .RDATA(RDATA), .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
    .MEM_WD(MEM_WD), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
  );

  // ---------------- memory environment (synchronous read, combinational sizing)
  logic [7:0]  envmem [0:1023];
  logic [31:0] rword, io_in, sh;
  logic [9:0]  ea;
  logic        mem_clr;
  int          cyc = 0;

  assign ea = MEM_ADDR2[9:0];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) envmem[i] <= 8'h00;
    end else if (MEM_WE2 && MEM_ADDR2 < MMIO_BASE) begin
      envmem[ea] <= MEM_WD[7:0];
      if (MEM_SIZE != SZ_BYTE) envmem[ea + 10'd1] <= MEM_WD[15:8];
      if (MEM_SIZE == SZ_WORD) begin
        envmem[ea + 10'd2] <= MEM_WD[23:16];
        envmem[ea + 10'd3] <= MEM_WD[31:24];
      end
    end
  end

  always @(posedge CLK) begin
    if (MEM_RDEN2) begin
      rword <= (MEM_ADDR2 >= MMIO_BASE) ? io_in :
               {envmem[{ea[9:2], 2'd3}], envmem[{ea[9:2], 2'd2}],
                envmem[{ea[9:2], 2'd1}], envmem[{ea[9:2], 2'd0}]};
    end
  end

  always_comb begin
    sh = rword >> (8 * MEM_ADDR2[1:0]);
    case (MEM_SIZE)
      SZ_BYTE: MEM_DOUT2 = MEM_SIGN ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: MEM_DOUT2 = MEM_SIGN ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: MEM_DOUT2 = rword;
    endcase
  end

  // ---------------- reference model
  typedef struct {
    bit          v;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  size;
    logic        sign;
    bit          has_exp;
    logic [31:0] exp;
  } txn_t;

  typedef struct {
    logic [1:0]  gnt;
    logic        we;
    logic        rden;
    logic [31:0] addr;
    bit          addr_chk;
  } cyc_t;

  typedef struct {
    int          owner;
    logic [31:0] data;
    int          cyc;
  } ret_t;

  logic [7:0]  refmem [0:1023];
  txn_t        pend [2];
  cyc_t        cq [$];
  ret_t        rq [$];
  ret_t        nxt;
  bit          busy;
  int          last;
  logic [31:0] hold_addr;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sg);
    logic [9:0]  i;
    logic [15:0] h;
    i = a[9:0];
    if (a >= MMIO_BASE) return io_in;
    case (sz)
      SZ_BYTE: return sg ? {24'h0, refmem[i]} : {{24{refmem[i][7]}}, refmem[i]};
      SZ_HALF: begin
        h = {refmem[i + 10'd1], refmem[i]};
        return sg ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return {refmem[i + 10'd3], refmem[i + 10'd2], refmem[i + 10'd1], refmem[i]};
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    logic [9:0] i;
    i = a[9:0];
    if (a >= MMIO_BASE) return;
    for (int k = 0; k < 4; k++) begin
      if (k == 0 || (k == 1 && sz != SZ_BYTE) || sz == SZ_WORD)
        refmem[i + 10'(k)] = wd[8*k +: 8];
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.v       = 1'b1;
    t.we      = 1'($urandom_range(0, 1));
    t.size    = 2'($urandom_range(0, 2));
    t.sign    = 1'($urandom_range(0, 1));
    t.wd      = $urandom;
    t.addr    = 32'($urandom_range(0, 255));
    if (t.size == SZ_HALF) t.addr[0] = 1'b0;
    if (t.size == SZ_WORD) t.addr[1:0] = 2'b00;
    t.has_exp = 1'b0;
    t.exp     = 32'h0;
    return t;
  endfunction

  function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] sz, input logic sg, input bit he,
                              input logic [31:0] ex);
    txn_t t;
    t.v = 1'b1; t.we = we; t.addr = a; t.wd = wd; t.size = sz; t.sign = sg;
    t.has_exp = he; t.exp = ex;
    return t;
  endfunction

  // One clock of stimulus plus prediction; idle masters drive junk attributes.
  task automatic step(input logic rst);
    cyc_t c;
    txn_t d0, d1;
    int   w;
    d0 = pend[0];
    d1 = pend[1];
    if (!d0.v) begin d0 = rand_txn(); d0.v = 1'b0; end
    if (!d1.v) begin d1 = rand_txn(); d1.v = 1'b0; end
    RST = rst;
    M0_REQ = d0.v; M0_WE = d0.we; M0_ADDR = d0.addr; M0_WD = d0.wd;
    M0_SIZE = d0.size; M0_SIGN = d0.sign;
    M1_REQ = d1.v; M1_WE = d1.we; M1_ADDR = d1.addr; M1_WD = d1.wd;
    M1_SIZE = d1.size; M1_SIGN = d1.sign;
    c.gnt = 2'b00; c.we = 1'b0; c.rden = 1'b0; c.addr = 32'h0; c.addr_chk = 1'b1;
    if (rst) begin
      busy = 1'b0;
      last = 1;
      c.addr_chk = 1'b0;
    end else if (busy) begin
      c.addr = hold_addr;
      nxt.cyc = cyc;
      rq.push_back(nxt);
      busy = 1'b0;
    end else if (pend[0].v || pend[1].v) begin
      if (pend[0].v && pend[1].v) w = (RR && last == 0) ? 1 : 0;
      else w = pend[0].v ? 0 : 1;
      c.gnt  = (w == 0) ? 2'b01 : 2'b10;
      c.addr = pend[w].addr;
      if (pend[w].we) begin
        c.we = 1'b1;
        ref_store(pend[w].addr, pend[w].wd, pend[w].size);
      end else begin
        c.rden    = 1'b1;
        busy      = 1'b1;
        hold_addr = pend[w].addr;
        nxt.owner = w;
        nxt.data  = pend[w].has_exp ? pend[w].exp
                                    : ref_load(pend[w].addr, pend[w].size, pend[w].sign);
      end
      last = w;
      pend[w].v = 1'b0;
    end
    cq.push_back(c);
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((pend[0].v || pend[1].v || busy) && n < 20) begin
      step(1'b0);
      n++;
    end
    check("drain_timeout", 32'(n), (n < 20) ? 32'(n) : 32'hFFFF_FFFF);
  endtask

  // ---------------- monitor
  initial begin : mon
    cyc_t c;
    ret_t r;
    forever begin
      @(negedge CLK);
      if (cq.size() != 0) begin
        c = cq.pop_front();
        check("gnt", {30'd0, M1_GNT, M0_GNT}, {30'd0, c.gnt});
        check("mem_we2", {31'd0, MEM_WE2}, {31'd0, c.we});
        check("mem_rden2", {31'd0, MEM_RDEN2}, {31'd0, c.rden});
        if (c.addr_chk) check("mem_addr2", MEM_ADDR2, c.addr);
      end
      check("rvalid_onehot", {31'd0, M0_RVALID & M1_RVALID}, 32'd0);
      if (M0_RVALID || M1_RVALID) begin
        if (rq.size() == 0) begin
          check("rvalid_unexpected", {30'd0, M1_RVALID, M0_RVALID}, 32'd0);
        end else begin
          r = rq.pop_front();
          check("rvalid_owner", {30'd0, M1_RVALID, M0_RVALID}, (r.owner == 0) ? 32'd1 : 32'd2);
          check("rdata", RDATA, r.data);
          check("rvalid_cycle", 32'(cyc), 32'(r.cyc));
        end
      end
    end
  end

  // ---------------- stimulus
  initial begin
    RST = 1'b1; mem_clr = 1'b1; io_in = 32'h0; busy = 1'b0; last = 1;
    M0_REQ = 1'b0; M0_WE = 1'b0; M0_ADDR = 32'h0; M0_WD = 32'h0; M0_SIZE = 2'd0; M0_SIGN = 1'b0;
    M1_REQ = 1'b0; M1_WE = 1'b0; M1_ADDR = 32'h0; M1_WD = 32'h0; M1_SIZE = 2'd0; M1_SIGN = 1'b0;
    for (int i = 0; i < 1024; i++) refmem[i] = 8'h00;
    pend[0].v = 1'b0;
    pend[1].v = 1'b0;
    @(posedge CLK);
    #1;
    mem_clr = 1'b0;

    // Reset with both requesting, then M0 first.
    pend[0] = mk(1'b0, 32'h40, 32'h0, SZ_WORD, 1'b0, 1'b0, 32'h0);
    pend[1] = mk(1'b0, 32'h44, 32'h0, SZ_WORD, 1'b0, 1'b0, 32'h0);
    step(1'b1);
    step(1'b1);
    drain();

    // Store word, then signed half load from the upper half.
    pend[0] = mk(1'b1, 32'h100, 32'hDEADBEEF, SZ_WORD, 1'b0, 1'b0, 32'h0);
    drain();
    pend[0] = mk(1'b0, 32'h102, 32'h0, SZ_HALF, 1'b0, 1'b1, 32'hFFFFDEAD);
    drain();

    // Back-to-back byte stores from M1, then a word load.
    pend[1] = mk(1'b1, 32'h200, 32'h11, SZ_BYTE, 1'b0, 1'b0, 32'h0);
    step(1'b0);
    pend[1] = mk(1'b1, 32'h201, 32'h22, SZ_BYTE, 1'b0, 1'b0, 32'h0);
    step(1'b0);
    pend[1] = mk(1'b1, 32'h202, 32'h33, SZ_BYTE, 1'b0, 1'b0, 32'h0);
    step(1'b0);
    pend[1] = mk(1'b0, 32'h200, 32'h0, SZ_WORD, 1'b0, 1'b1, 32'h00332211);
    drain();

    // Contention: both masters keep word loads pending.
    for (int k = 0; k < 8; k++) begin
      if (!pend[0].v) pend[0] = mk(1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0, 1'b0, 32'h0);
      if (!pend[1].v) pend[1] = mk(1'b0, 32'h200, 32'h0, SZ_WORD, 1'b0, 1'b0, 32'h0);
      step(1'b0);
    end
    drain();

    // Reset during the read-return cycle drops the load.
    pend[1] = mk(1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0, 1'b0, 32'h0);
    step(1'b0);
    step(1'b1);
    pend[0] = mk(1'b0, 32'h200, 32'h0, SZ_BYTE, 1'b1, 1'b0, 32'h0);
    drain();

    // MMIO load.
    io_in = 32'h0000_00A5;
    pend[0] = mk(1'b0, 32'h1100_0000, 32'h0, SZ_WORD, 1'b0, 1'b1, 32'h0000_00A5);
    drain();
    io_in = 32'h0;

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      if (!pend[0].v && $urandom_range(0, 3) != 0) pend[0] = rand_txn();
      if (!pend[1].v && $urandom_range(0, 3) != 0) pend[1] = rand_txn();
      step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end
    drain();
    step(1'b0);

    check("ret_pending", 32'(rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/otter_mem_arbiter.md
# otter_mem_arbiter

Two-requester arbiter and sequencer for the OTTER memory data port (port 2). Shares the single data port between the CPU load/store path (M0) and a secondary master (M1, debug loader or DMA). Issues one transaction at a time and holds the address, size and sign steady through the synchronous-read return cycle, because the memory sizes and sign-extends read data combinationally from the current address and size. The instruction port (port 1) is not touched.

## Interface
Parameters:
- None. Widths are fixed: 32-bit address and data, 2-bit size.

Ports:
- CLK  in  1  system clock; memory shares this clock.
- RST  in  1  synchronous, active-high reset.
- M0_REQ  in  1  CPU request; held with its attributes until M0_GNT.
- M0_WE  in  1  1 = store, 0 = load.
- M0_ADDR  in  32  byte address.
- M0_WD  in  32  store data.
- M0_SIZE  in  2  0 = byte, 1 = half, 2 = word.
- M0_SIGN  in  1  1 = unsigned, 0 = signed.
- M0_GNT  out  1  request accepted this cycle.
- M0_RVALID  out  1  RDATA holds M0 load data this cycle.
- M1_REQ, M1_WE, M1_ADDR, M1_WD, M1_SIZE, M1_SIGN, M1_GNT, M1_RVALID: same as M0, for the secondary master.
- RDATA  out  32  shared load-return data (MEM_DOUT2 pass-through).
- MEM_RDEN2  out  1  to memory read enable.
- MEM_WE2  out  1  to memory write enable.
- MEM_ADDR2  out  32  to memory data address.
- MEM_WD  out  32  to memory write data.
- MEM_SIZE  out  2  to memory access size.
- MEM_SIGN  out  1  to memory sign select.
- MEM_DOUT2  in  32  from memory, sized load data.

## Operation
- States: IDLE and RD_DATA.
- **IDLE:**
  - Arbitrate among the asserted REQs and assert the winner's GNT combinationally in the same cycle.
  - Drive the winner's ADDR, WD, SIZE and SIGN onto the MEM_* outputs.
  - Store (WE = 1): MEM_WE2 = 1 and MEM_RDEN2 = 0. Stay in IDLE, so back-to-back stores from either master are possible.
  - Load (WE = 0): MEM_RDEN2 = 1 and MEM_WE2 = 0. Register the owner, ADDR, SIZE and SIGN, then go to RD_DATA.
  - No request: all MEM_* enables are 0, and the address, size and sign outputs are 0.
- **RD_DATA:**
  - Drive MEM_ADDR2, MEM_SIZE and MEM_SIGN from the registered values. MEM_RDEN2 = 0 and MEM_WE2 = 0.
  - Assert the owner's RVALID; RDATA = MEM_DOUT2.
  - No GNT is issued in this state. Always return to IDLE the next cycle.
- Loads to MMIO addresses (≥ 0x00010000) follow the same sequence. MMIO stores also follow the same sequence, because the memory itself derives IO_WR.
- RDATA equals MEM_DOUT2 at all times; it is meaningful only when an RVALID is asserted.
- At most one GNT is asserted per cycle, and at most one RVALID is asserted per cycle.

## Timing
- Reset values:
  - State = IDLE; round-robin pointer favours M0.
  - All GNT, RVALID, MEM_RDEN2 and MEM_WE2 are 0 while RST = 1, regardless of REQ.
- Store latency: committed at the CLK edge ending the GNT cycle. Throughput is 1 store per cycle.
- Load latency: GNT in cycle N, RVALID in cycle N+1. Port occupancy is 2 cycles, so throughput is 1 load per 2 cycles.
- Handshake: a master must hold REQ and its attributes stable until GNT. After a load GNT, attributes may change; the arbiter uses its registered copy.
- A master may hold REQ continuously to issue consecutive transactions. Each GNT cycle is one transaction.
- Simultaneous REQ: resolved as described under Configuration. The loser's REQ remains pending with no timeout.
- Reset during RD_DATA: RVALID is suppressed from the reset cycle onward, and the pending load is dropped.

## Configuration
- Macro: `OTTER_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - A one-bit pointer records the last master granted.
  - On a conflict, the other master wins.
  - The pointer updates on every GNT, including uncontested ones.
- Undefined: fixed priority, M0 always wins, and the pointer logic is removed. M1 can be starved by a continuous M0 request; this is accepted for CPU-critical builds.

## Structure
- Shared package `otter_mem_pkg` holds:
  - size encodings: SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2;
  - the MMIO base constant MMIO_BASE = 32'h00010000;
  - the arbiter state enum {IDLE, RD_DATA}.
- One natural sub-module, `otter_arb2`. It contains:
  - the two-way grant logic;
  - the round-robin pointer, compiled under `OTTER_ARB_RR_EN`.
- The top level contains the state machine, the attribute registers and the output muxing.

## Test plan
1. **Reset:** assert RST for 2 cycles with M0_REQ = M1_REQ = 1 → no GNT, MEM_WE2 = 0 and MEM_RDEN2 = 0 throughout. The first post-reset cycle grants M0.
2. **Store then load:**
   - M0 stores word 0xDEADBEEF to address 0x100.
   - M0 then loads half, signed, from 0x102 → GNT in cycle N, M0_RVALID in cycle N+1, RDATA = 0xFFFFDEAD.
   - During cycle N+1, MEM_ADDR2 stays 0x102.
3. **Back-to-back stores:**
   - M1 holds REQ with byte stores 0x11, 0x22, 0x33 to 0x200–0x202 → 3 consecutive GNT cycles.
   - A word load from 0x200 then returns 0x00332211.
4. **Contention, round robin:** both masters hold REQ with word loads → grants alternate M0, M1, M0, M1 on cycles 0, 2, 4, 6; RVALID follows on cycles 1, 3, 5, 7. Without `OTTER_ARB_RR_EN`, only M0 is granted.
5. **Reset mid-read:** M1 load granted in cycle N, RST asserted in cycle N+1 → M1_RVALID stays 0, state is IDLE after reset.
6. **MMIO load:** M0 loads from 0x11000000 with IO_IN = 0x000000A5 → M0_RVALID one cycle after GNT, RDATA = 0x000000A5.
